// File: rtl/branch_compare_pipe.sv
// branch_compare_pipe: pipelined ten-mode branch comparator with tag, mispredict flag and saturating retire counters
module branch_compare_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             pred_taken,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic             out_op_err,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);
  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("branch_compare_pipe: STAGES must be 1..3");
  end
  logic eq, lt_s, lt_u, lez, taken_c, err_c, retire;
  logic [STAGES-1:0] v_q, t_q, m_q, e_q;
  logic [TAG_W-1:0] tag_q [STAGES];
  logic [CNT_W-1:0] bc_q, bc_d, mc_q, mc_d;
  always_comb begin
    eq      = in1 == in2;
    lt_s    = $signed(in1) < $signed(in2);
    lt_u    = in1 < in2;
    lez     = in1[WIDTH-1] | ~|in1;
    err_c   = op > 4'd9;
    taken_c = op == 4'd0 ? eq :
              op == 4'd1 ? ~eq :
              op == 4'd2 ? lt_s :
              op == 4'd3 ? ~lt_s :
              op == 4'd4 ? lt_u :
              op == 4'd5 ? ~lt_u :
              op == 4'd6 ? lez :
              op == 4'd7 ? ~lez :
              op == 4'd8 ? in1[WIDTH-1] :
              op == 4'd9 ? ~in1[WIDTH-1] : 1'b0;
    retire  = v_q[STAGES-1] & ~stall & ~flush;
    bc_d    = retire && ~&bc_q ? bc_q + CNT_W'(1) : bc_q;
    mc_d    = retire && m_q[STAGES-1] && ~&mc_q ? mc_q + CNT_W'(1) : mc_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q  <= '0;
      bc_q <= '0;
      mc_q <= '0;
    end else begin
      v_q  <= flush ? '0 : stall ? v_q : (v_q << 1) | STAGES'(in_valid);
      bc_q <= bc_d;
      mc_q <= mc_d;
    end
  always_ff @(posedge clk)
    if (!stall) begin
      t_q      <= (t_q << 1) | STAGES'(taken_c);
      m_q      <= (m_q << 1) | STAGES'(taken_c ^ pred_taken);
      e_q      <= (e_q << 1) | STAGES'(err_c);
      tag_q[0] <= in_tag;
      for (int i = 1; i < STAGES; i++) tag_q[i] <= tag_q[i-1];
    end
  assign out_valid      = v_q[STAGES-1];
  assign out_taken      = out_valid & t_q[STAGES-1];
  assign out_mispredict = out_valid & m_q[STAGES-1];
  assign out_op_err     = out_valid & e_q[STAGES-1];
  assign out_tag        = out_valid ? tag_q[STAGES-1] : '0;
  assign branch_cnt     = bc_q;
  assign mispred_cnt    = mc_q;
endmodule

// File: tb/tb_branch_compare_pipe.sv
// tb_branch_compare_pipe: directed plus random checks of two configurations against a queue-based reference
module tb_branch_compare_pipe;
  logic clk = 0, rst_n = 0, in_valid = 0, stall = 0, flush = 0, pred_taken = 0;
  logic [3:0] op = 0;
  logic [31:0] in1 = 0, in2 = 0;
  logic [4:0] in_tag = 0;
  logic a_v, a_t, a_m, a_e, b_v, b_t, b_m, b_e;
  logic [4:0] a_tag, b_tag;
  logic [15:0] a_bc, a_mc;
  logic [3:0] b_bc, b_mc;
  always #5 clk = ~clk;
  branch_compare_pipe #(.WIDTH(32), .STAGES(1), .TAG_W(5), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush), .op(op),
    .in1(in1), .in2(in2), .pred_taken(pred_taken), .in_tag(in_tag),
    .out_valid(a_v), .out_taken(a_t), .out_mispredict(a_m), .out_op_err(a_e), .out_tag(a_tag),
    .branch_cnt(a_bc), .mispred_cnt(a_mc));
  branch_compare_pipe #(.WIDTH(32), .STAGES(3), .TAG_W(5), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush), .op(op),
    .in1(in1), .in2(in2), .pred_taken(pred_taken), .in_tag(in_tag),
    .out_valid(b_v), .out_taken(b_t), .out_mispredict(b_m), .out_op_err(b_e), .out_tag(b_tag),
    .branch_cnt(b_bc), .mispred_cnt(b_mc));
  typedef struct {int m; int age; logic t; logic mp; logic e; logic [4:0] tag;} ent_t;
  ent_t q[$];
  int bc[2] = '{0, 0};
  int mc[2] = '{0, 0};
  int lat[2] = '{1, 3};
  int cmax[2] = '{65535, 15};
  int errors = 0, checks = 0;
  function automatic logic [2:0] ref_res(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic p);
    longint sa, sb, ua, ub;
    logic t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    t = 1'b0;
    case (o)
      4'd0: t = ua == ub;
      4'd1: t = ua != ub;
      4'd2: t = sa < sb;
      4'd3: t = sa >= sb;
      4'd4: t = ua < ub;
      4'd5: t = ua >= ub;
      4'd6: t = sa <= 0;
      4'd7: t = sa > 0;
      4'd8: t = sa < 0;
      4'd9: t = sa >= 0;
      default: return {1'b0, p, 1'b1};
    endcase
    return {t, t ^ p, 1'b0};
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'h7fff_ffff;
      4: return 32'hffff_ffff;
      default: return $urandom;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    bc = '{0, 0};
    mc = '{0, 0};
  endtask
  task automatic model_edge();
    ent_t nq[$];
    ent_t e;
    logic [2:0] r;
    if (!rst_n) model_reset();
    else if (flush) q.delete();
    else if (!stall) begin
      foreach (q[i]) begin
        e = q[i];
        if (e.age == lat[e.m]) begin
          if (bc[e.m] < cmax[e.m]) bc[e.m]++;
          if (e.mp && mc[e.m] < cmax[e.m]) mc[e.m]++;
        end else begin
          e.age++;
          nq.push_back(e);
        end
      end
      if (in_valid) begin
        r = ref_res(op, in1, in2, pred_taken);
        for (int m = 0; m < 2; m++) nq.push_back('{m, 1, r[2], r[1], r[0], in_tag});
      end
      q = nq;
    end
  endtask
  task automatic check_all();
    logic ev, et, em, ee;
    logic [4:0] etg;
    for (int m = 0; m < 2; m++) begin
      {ev, et, em, ee, etg} = '0;
      foreach (q[i]) if (q[i].m == m && q[i].age == lat[m]) {ev, et, em, ee, etg} = {1'b1, q[i].t, q[i].mp, q[i].e, q[i].tag};
      if (m == 0) begin
        chk("a_valid", a_v, ev);
        chk("a_taken", a_t, et);
        chk("a_mispred", a_m, em);
        chk("a_op_err", a_e, ee);
        chk("a_tag", a_tag, etg);
        chk("a_branch_cnt", a_bc, bc[0]);
        chk("a_mispred_cnt", a_mc, mc[0]);
      end else begin
        chk("b_valid", b_v, ev);
        chk("b_taken", b_t, et);
        chk("b_mispred", b_m, em);
        chk("b_op_err", b_e, ee);
        chk("b_tag", b_tag, etg);
        chk("b_branch_cnt", b_bc, bc[1]);
        chk("b_mispred_cnt", b_mc, mc[1]);
      end
    end
  endtask
  task automatic cyc(input logic iv, input logic st, input logic fl, input logic [3:0] o,
                     input logic [31:0] x, input logic [31:0] y, input logic p, input logic [4:0] t);
    in_valid = iv; stall = st; flush = fl; op = o; in1 = x; in2 = y; pred_taken = p; in_tag = t;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask
  initial begin
    logic [3:0] sw_op [8] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    logic sw_exp [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 4'd0, 32'h1234, 32'h1234, 0, 5'd7);
    chk("eq_taken", a_t, 1'b1);
    chk("eq_mispred", a_m, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("eq_mispred_cnt", a_mc, 16'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, sw_op[i], 32'h8000_0000, 32'h1, 0, 5'(i));
      chk("sweep_taken", a_t, sw_exp[i]);
    end
    cyc(1, 0, 0, 4'd2, 32'h8000_0000, 32'h0, 0, 5'd20);
    chk("edge_lt", a_t, 1'b1);
    cyc(1, 0, 0, 4'd4, 32'h8000_0000, 32'h0, 0, 5'd21);
    chk("edge_ltu", a_t, 1'b0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc(k <= 4, 0, 0, 4'd1, 32'(k), 32'h0, 1, 5'(k));
      if (k >= 3) chk("order_tag", b_tag, 32'(k - 2));
    end
    cyc(1, 0, 0, 4'd5, 32'h5, 32'h3, 0, 5'd11);
    cyc(1, 0, 0, 4'd3, 32'hffff_fff0, 32'h3, 1, 5'd12);
    cyc(1, 1, 0, 4'd0, 32'h0, 32'h0, 0, 5'd13);
    chk("stall_hold_tag", b_tag, 32'd0);
    cyc(1, 1, 0, 4'd0, 32'h0, 32'h0, 0, 5'd14);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("after_stall_tag", b_tag, 32'd11);
    cyc(1, 0, 1, 4'd0, 32'h0, 32'h0, 0, 5'd15);
    chk("flush_valid", b_v, 1'b0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 4'd12, 32'h1, 32'h1, 1, 5'd9);
    chk("illegal_taken", a_t, 1'b0);
    chk("illegal_err", a_e, 1'b1);
    chk("illegal_mispred", a_m, 1'b1);
    for (int k = 0; k < 20; k++) cyc(1, 0, 0, 4'd0, 32'h1, 32'h2, 1, 5'(k));
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_branch_cnt", b_bc, 32'd15);
    chk("sat_mispred_cnt", b_mc, 32'd15);
    cyc(1, 0, 0, 4'd1, 32'h1, 32'h2, 0, 5'd1);
    cyc(1, 0, 0, 4'd1, 32'h1, 32'h2, 0, 5'd2);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("async_rst_valid", b_v, 1'b0);
    chk("async_rst_cnt", b_bc, 32'd0);
    check_all();
    @(negedge clk);
    repeat (2) cyc(1, 0, 0, 4'd0, 32'h0, 32'h0, 0, 5'd3);
    rst_n = 1;
    for (int k = 0; k < 400; k++) begin
      logic [31:0] x;
      x = pick();
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
          4'($urandom_range(0, 15)), x, $urandom_range(0, 3) == 0 ? x : pick(),
          1'($urandom), 5'($urandom));
    end
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_compare_pipe.md
Name: branch_compare_pipe

Overview:
Parametrised, pipelined branch-resolution comparator for the MIPS pipeline. It generalises the single equality check to ten signed, unsigned and zero-relative compare modes, with 1–3 configurable register stages. Each result carries a tag and is checked against the fetch-stage prediction to flag a mispredict. Saturating counters track retired branches and mispredicts for performance monitoring.

Parameters:
WIDTH, 32, operand width in bits (≥2)
STAGES, 1, register stages from input to output; legal 1..3, any other value must fail elaboration
TAG_W, 5, width of the tag carried alongside each compare
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  a compare request is present this cycle
stall  in  1  hold the whole pipe and counters
flush  in  1  kill every in-flight entry
op  in  4  compare mode, encoding below
in1  in  WIDTH  operand A (rs)
in2  in  WIDTH  operand B (rt); ignored by zero-relative modes
pred_taken  in  1  fetch-stage prediction for this branch
in_tag  in  TAG_W  opaque request identifier
out_valid  out  1  a result is present at the final stage
out_taken  out  1  branch outcome
out_mispredict  out  1  out_taken != the entry's pred_taken
out_op_err  out  1  op was illegal; out_taken is forced to 0
out_tag  out  TAG_W  tag of the presented result
branch_cnt  out  CNT_W  retired valid results, saturating
mispred_cnt  out  CNT_W  retired mispredicts, saturating

Behaviour:
- op encoding:
  - 0 EQ (A==B); 1 NE; 2 LT signed A<B; 3 GE signed; 4 LTU; 5 GEU
  - 6 LEZ (A≤0 signed); 7 GTZ; 8 LTZ; 9 GEZ
  - 10–15 illegal: taken=0, op_err=1, mispredict = pred_taken
- Compare is combinational from the inputs. The result {taken, mispredict, op_err, tag} is captured into stage 1.
- Stage k+1 loads from stage k. Outputs come directly from the last stage register, so latency is exactly STAGES cycles with no stall.
- Per-edge priority: reset > flush > stall > normal.
  - flush: every stage valid bit ← 0. The output entry is not retired or counted, and in_valid that cycle is dropped.
  - stall (no flush): all stage registers, valid bits and counters hold. in_valid is ignored; the request is not captured, and the upstream stage must hold it.
  - normal: stage 1 valid ← in_valid. Each stage shifts. Bubbles propagate as valid=0 entries.
- Retirement: the output entry retires on an edge where out_valid=1, stall=0 and flush=0.
  - On retirement, branch_cnt += 1 and mispred_cnt += out_mispredict.
  - Each counter saturates at all-ones and never wraps.
- When out_valid=0: out_taken, out_mispredict, out_op_err and out_tag are don't-care to consumers. The implementation must drive 0 on all of them.
- Payload registers need not be reset, but the gated outputs must be 0 while invalid.
- Reset (async assert, sync-safe deassert by the system):
  - all valid bits 0
  - all outputs 0
  - both counters 0
  - in-flight entries are discarded, even mid-pipe
- Signedness: signed modes use two's-complement over WIDTH bits. Unsigned modes use magnitude.
  - Edge case A=100…0, B=0: LT=1, LTU=0.
- Back-to-back requests every cycle sustain one result per cycle with no gaps.

Test Plan:
- Reset then idle, STAGES=1: all outputs 0, counters 0. Request EQ, A=B=0x1234, pred_taken=0 → next cycle out_valid=1, taken=1, mispredict=1, mispred_cnt=1 after retire.
- Signed/unsigned sweep, A=0x80000000, B=0x00000001:
  - LT=1, GE=0, LTU=0, GEU=1
  - LEZ=1, GTZ=0, LTZ=1, GEZ=0 (B ignored)
- STAGES=3, four consecutive requests with tags 1..4 → results appear on cycles 3..6 in order; branch_cnt=4.
- Hold and flush, STAGES=3:
  - stall for 2 cycles with 2 entries in flight → outputs and counters hold, request presented during stall not captured.
  - then flush → out_valid=0 next edge, counters unchanged.
- op=12, pred_taken=1 → taken=0, op_err=1, mispredict=1.
- CNT_W=4: retire 20 mispredicting branches → both counters stop at 15. Assert rst_n mid-stream → all zero immediately, asynchronously.
